sha256_w_expander_pipe: RTL

SHA256_W_EXPANDER_PIPE -- requirements
Module: sha256_w_expander_pipe

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_w_step.sv | 14 +
 rtl/sha256_w_expander_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: sigma functions, padding
// constants for the 256-bit second block, and the expander state type.
package sha256_pkg;

   localparam logic [31:0] W8_PAD     = 32'h8000_0000;
   localparam logic [31:0] W15_LEN256 = 32'h0000_0100;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } w_state_e;

   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One message-schedule word: W[j] = s1(W[j-2]) + W[j-7] + s0(W[j-15]) + W[j-16].
module sha256_w_step
   import sha256_pkg::*;
(
   input  logic [31:0] w_m2_i,
   input  logic [31:0] w_m7_i,
   input  logic [31:0] w_m15_i,
   input  logic [31:0] w_m16_i,
   output logic [31:0] w_o
);

   assign w_o = s1(w_m2_i) + w_m7_i + s0(w_m15_i) + w_m16_i;

endmodule

// File: rtl/sha256_w_expander_pipe.sv
// Streams the 64-word SHA-256 message schedule of one 512-bit block,
// WPC words per beat, from a sliding 16-word window.
module sha256_w_expander_pipe
   import sha256_pkg::*;
#(
   parameter int WPC = 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [511:0]       block_in,
   input  logic               second_blk,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [32*WPC-1:0]  w_out,
   output logic [5:0]         w_idx,
   output logic               last
);

   if (!(WPC == 1 || WPC == 2 || WPC == 4)) begin : g_bad_wpc
      $error("sha256_w_expander_pipe: WPC must be 1, 2 or 4");
   end

   localparam logic [5:0] T_LAST = 6'(64 - WPC);
   localparam logic [5:0] T_STEP = 6'(WPC);

   w_state_e    state_q, state_d;
   logic [5:0]  t_q, t_d;
   logic [31:0] window_q [16];
   logic [31:0] window_d [16];
   logic [31:0] shifted  [16];
   logic        accept, advance;

   assign accept  = (state_q == ST_IDLE) && in_valid;
   assign advance = (state_q == ST_EXPAND) && out_ready;

   // Step j may consume step j-2's result in the same cycle, so each step
   // owns its result net and the shifted window only collects them.
   for (genvar j = 0; j < WPC; j++) begin : g_step
      logic [31:0] w;
      logic [31:0] m2;
      if (j >= 2) begin : g_chain
         assign m2 = g_step[j-2].w;
      end else begin : g_win
         assign m2 = window_q[14+j];
      end
      sha256_w_step u_step (
         .w_m2_i  (m2),
         .w_m7_i  (window_q[9+j]),
         .w_m15_i (window_q[1+j]),
         .w_m16_i (window_q[j]),
         .w_o     (w)
      );
      assign shifted[16-WPC+j] = w;
   end

   for (genvar i = 0; i < 16 - WPC; i++) begin : g_shift
      assign shifted[i] = window_q[i+WPC];
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (in_valid) state_d = ST_EXPAND;
         ST_EXPAND: if (out_ready && (t_q == T_LAST)) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_EXPAND);
      last      = (state_q == ST_EXPAND) && (t_q == T_LAST);
      w_idx     = t_q;
      w_out     = '0;
      for (int k = 0; k < WPC; k++) begin
         w_out[32*(WPC-k)-1 -: 32] = window_q[k];
      end
   end

   always_comb begin
      window_d = window_q;
      t_d      = t_q;
      if (accept) begin
         t_d = '0;
         for (int i = 0; i < 16; i++) window_d[i] = block_in[511-32*i -: 32];
         // Second block of a double hash: 256-bit digest followed by fixed padding.
         if (second_blk) begin
            for (int i = 0; i < 8; i++) window_d[i] = block_in[255-32*i -: 32];
            window_d[8] = W8_PAD;
            for (int i = 9; i < 15; i++) window_d[i] = '0;
            window_d[15] = W15_LEN256;
         end
      end else if (advance) begin
         window_d = shifted;
         t_d      = (t_q == T_LAST) ? 6'd0 : t_q + T_STEP;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         t_q <= '0;
         for (int i = 0; i < 16; i++) window_q[i] <= '0;
      end else begin
         t_q      <= t_d;
         window_q <= window_d;
      end
   end

endmodule
